// File: rtl/dmem_lsu_pkg.sv
// rtl/dmem_lsu_pkg.sv - shared size encodings, FSM states and parameter defaults for dmem_lsu
package dmem_lsu_pkg;

  localparam int XLEN_DEF       = 32;
  localparam int ADDR_WIDTH_DEF = 10;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - picks the addressed byte/half/word out of a memory word and sign/zero extends it
module load_align
  import dmem_lsu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0]            i_word,
  input  logic [$clog2(XLEN/8)-1:0]  i_off,
  input  logic [1:0]                 i_size,
  input  logic                       i_unsigned,
  output logic [XLEN-1:0]            o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Half offsets are already even here; misaligned halves never reach a data path.
  assign w_byte = 8'(i_word >> {i_off, 3'b000});
  assign w_half = 16'(i_word >> {i_off, 3'b000});

  always_comb begin
    o_data = '0;
    case (size_e'(i_size))
      SZ_BYTE: o_data = {{(XLEN-8){~i_unsigned & w_byte[7]}}, w_byte};
      SZ_HALF: o_data = {{(XLEN-16){~i_unsigned & w_half[15]}}, w_half};
      SZ_WORD: o_data = i_word;
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - single-port data memory with self-initialisation sweep and pipelined load/store port
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int RD_LATENCY   = 1,
  parameter int INIT_PATTERN = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [XLEN-1:0]       req_wdata,
  output logic                  rsp_valid,
  output logic [XLEN-1:0]       rsp_rdata,
  output logic                  rsp_err
);

  localparam int NB    = XLEN / 8;
  localparam int OFFB  = $clog2(NB);
  localparam int WIDX  = ADDR_WIDTH - OFFB;
  localparam int DEPTH = 2 ** WIDX;

  state_e          r_state, w_state_nxt;
  logic [WIDX-1:0] r_init_cnt;
  logic [XLEN-1:0] r_mem [DEPTH];
  logic [XLEN-1:0] r_rd_word;

  logic            w_accept, w_store, w_err;
  logic [OFFB-1:0] w_off;
  logic [WIDX-1:0] w_widx;
  logic [NB-1:0]   w_be;
  logic [XLEN-1:0] w_wdata_rep;

  logic            r_s1_valid, r_s1_we, r_s1_err, r_s1_uns;
  logic [1:0]      r_s1_size;
  logic [OFFB-1:0] r_s1_off;
  logic [XLEN-1:0] w_ld_data, w_s1_rdata;
  logic            w_s1_err;

  assign w_off    = req_addr[OFFB-1:0];
  assign w_widx   = req_addr[ADDR_WIDTH-1:OFFB];
  assign w_accept = req_valid & req_ready;
  assign w_store  = w_accept & req_we;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_INIT) r_init_cnt <= r_init_cnt + WIDX'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    case (r_state)
      ST_INIT: if (&r_init_cnt) w_state_nxt = ST_RUN;
      ST_RUN:  req_ready = 1'b1;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone select what lands.
  always_comb begin
    w_err       = 1'b0;
    w_be        = '0;
    w_wdata_rep = req_wdata;
    case (size_e'(req_size))
      SZ_BYTE: begin
        w_be        = NB'(1) << w_off;
        w_wdata_rep = {NB{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        w_err       = w_off[0];
        w_be        = NB'(3) << w_off;
        w_wdata_rep = {(NB/2){req_wdata[15:0]}};
      end
      SZ_WORD: begin
        w_err = |w_off;
        w_be  = '1;
      end
      default: w_err = 1'b1;
    endcase
    if (w_err) w_be = '0;
  end

  // The array is deliberately outside the reset domain; INIT defines its contents.
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_mem[r_init_cnt] <= (INIT_PATTERN != 0) ? XLEN'(r_init_cnt) : '0;
    end else if (w_store) begin
      for (int b = 0; b < NB; b++) begin
        if (w_be[b]) r_mem[w_widx][b*8 +: 8] <= w_wdata_rep[b*8 +: 8];
      end
    end
    if (w_accept && !req_we) r_rd_word <= r_mem[w_widx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_we    <= 1'b0;
      r_s1_err   <= 1'b0;
      r_s1_uns   <= 1'b0;
      r_s1_size  <= '0;
      r_s1_off   <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_we   <= req_we;
        r_s1_err  <= w_err;
        r_s1_uns  <= req_unsigned;
        r_s1_size <= req_size;
        r_s1_off  <= w_off;
      end
    end
  end

  load_align #(.XLEN(XLEN)) u_load_align (
    .i_word     (r_rd_word),
    .i_off      (r_s1_off),
    .i_size     (r_s1_size),
    .i_unsigned (r_s1_uns),
    .o_data     (w_ld_data)
  );

  assign w_s1_rdata = (r_s1_valid && !r_s1_we && !r_s1_err) ? w_ld_data : '0;
  assign w_s1_err   = r_s1_valid & r_s1_err;

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic            r_s2_valid, r_s2_err;
      logic [XLEN-1:0] r_s2_rdata;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_s2_valid <= 1'b0;
          r_s2_err   <= 1'b0;
          r_s2_rdata <= '0;
        end else begin
          r_s2_valid <= r_s1_valid;
          r_s2_err   <= w_s1_err;
          r_s2_rdata <= w_s1_rdata;
        end
      end
      assign rsp_valid = r_s2_valid;
      assign rsp_err   = r_s2_err;
      assign rsp_rdata = r_s2_rdata;
    end else begin : g_lat1
      assign rsp_valid = r_s1_valid;
      assign rsp_err   = w_s1_err;
      assign rsp_rdata = w_s1_rdata;
    end
  endgenerate

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - randomized and directed bench for dmem_lsu at read latency 1 and 2
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [9:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rdy1, rdy2, v1, v2, e1, e2;
  logic [31:0] d1, d2;

  always #5 clk = ~clk;

  dmem_lsu #(.RD_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy1), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(v1), .rsp_rdata(d1), .rsp_err(e1)
  );

  dmem_lsu #(.RD_LATENCY(2)) u_dut2 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy2), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(v2), .rsp_rdata(d2), .rsp_err(e2)
  );

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] rd;
  } exp_t;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [7:0]  model_mem [1024];
  exp_t        q1[$];
  exp_t        q2[$];
  logic [31:0] last_rd1 = '0, last_rd2 = '0;
  logic        last_err1 = 1'b0, last_err2 = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic void model_init();
    logic [31:0] w;
    for (int a = 0; a < 1024; a++) begin
      w = 32'(a / 4);
      model_mem[a] = w[8*(a%4) +: 8];
    end
  endfunction

  function automatic void model_req(input logic we, input logic [1:0] sz, input logic uns,
                                    input logic [9:0] a, input logic [31:0] wd,
                                    output logic err, output logic [31:0] rd);
    int nbytes;
    logic [31:0] val;
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    err = (sz == 2'd3) || ((int'(a) % nbytes) != 0);
    rd  = '0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < nbytes; i++) model_mem[int'(a) + i] = wd[8*i +: 8];
      end else begin
        val = '0;
        for (int i = 0; i < nbytes; i++) val = val | (32'(model_mem[int'(a) + i]) << (8*i));
        if (!uns && nbytes < 4 && val[8*nbytes-1]) val = val | (32'hFFFF_FFFF << (8*nbytes));
        rd = val;
      end
    end
  endfunction

  task automatic check_rsp();
    logic x1, x2;
    while (q1.size() > 0 && q1[0].due < cyc) void'(q1.pop_front());
    while (q2.size() > 0 && q2[0].due < cyc) void'(q2.pop_front());
    x1 = (q1.size() > 0) && (q1[0].due == cyc);
    x2 = (q2.size() > 0) && (q2[0].due == cyc);
    check("rsp_valid_lat1", 32'(v1), 32'(x1));
    check("rsp_valid_lat2", 32'(v2), 32'(x2));
    if (x1) begin
      check("rdata_lat1", d1, q1[0].rd);
      check("err_lat1", 32'(e1), 32'(q1[0].err));
      last_rd1 = d1; last_err1 = e1;
      void'(q1.pop_front());
    end
    if (x2) begin
      check("rdata_lat2", d2, q2[0].rd);
      check("err_lat2", 32'(e2), 32'(q2[0].err));
      last_rd2 = d2; last_err2 = e2;
      void'(q2.pop_front());
    end
  endtask

  task automatic step(input logic v, input logic we, input logic [1:0] sz, input logic uns,
                      input logic [9:0] a, input logic [31:0] wd);
    logic acc1, acc2, err;
    logic [31:0] rd;
    exp_t e;
    req_valid = v; req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    acc1 = v && rdy1;
    acc2 = v && rdy2;
    err = 1'b0; rd = '0;
    if (acc1 || acc2) model_req(we, sz, uns, a, wd, err, rd);
    @(posedge clk);
    cyc++;
    e.err = err; e.rd = rd;
    if (acc1) begin e.due = cyc;     q1.push_back(e); end
    if (acc2) begin e.due = cyc + 1; q2.push_back(e); end
    @(negedge clk);
    check_rsp();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 2'd0, 1'b0, 10'd0, 32'd0);
  endtask

  task automatic ld_expect(input string tag, input logic [1:0] sz, input logic uns,
                           input logic [9:0] a, input logic [31:0] exp);
    step(1'b1, 1'b0, sz, uns, a, 32'd0);
    idle(2);
    check({tag, "_lat1"}, last_rd1, exp);
    check({tag, "_lat2"}, last_rd2, exp);
  endtask

  task automatic err_expect(input string tag, input logic we, input logic [1:0] sz, input logic [9:0] a);
    last_err1 = 1'b0; last_err2 = 1'b0; last_rd1 = 32'hFFFF_FFFF; last_rd2 = 32'hFFFF_FFFF;
    step(1'b1, we, sz, 1'b0, a, 32'hDEAD_BEEF);
    idle(2);
    check({tag, "_err1"}, 32'(last_err1), 32'd1);
    check({tag, "_err2"}, 32'(last_err2), 32'd1);
    check({tag, "_rdata1"}, last_rd1, 32'd0);
  endtask

  task automatic apply_reset();
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_ready", 32'(rdy1), 32'd0);
    check("rst_valid_lat1", 32'(v1), 32'd0);
    check("rst_valid_lat2", 32'(v2), 32'd0);
    check("rst_rdata_lat1", d1, 32'd0);
    check("rst_rdata_lat2", d2, 32'd0);
    check("rst_err", 32'(e1 | e2), 32'd0);
    q1.delete(); q2.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    bit saw = 1'b0;
    while (!rdy1 && n < 400) begin
      n++;
      if (v1 || v2) saw = 1'b1;
      @(negedge clk);
    end
    check({tag, "_init_cycles"}, 32'(n), 32'd256);
    check({tag, "_no_stale_rsp"}, 32'(saw), 32'd0);
    check({tag, "_ready_lat2"}, 32'(rdy2), 32'd1);
    model_init();
    q1.delete(); q2.delete();
    cyc = 0;
  endtask

  initial begin
    model_init();
    @(negedge clk);
    apply_reset();
    wait_init("boot");
    ld_expect("load_w010", 2'd2, 1'b0, 10'h010, 32'h0000_0004);

    step(1'b1, 1'b1, 2'd2, 1'b0, 10'h020, 32'h1122_3344);
    step(1'b1, 1'b1, 2'd0, 1'b0, 10'h021, 32'h0000_00AB);
    ld_expect("byte_merge", 2'd2, 1'b0, 10'h020, 32'h1122_AB44);

    step(1'b1, 1'b1, 2'd2, 1'b0, 10'h040, 32'h0000_80FF);
    ld_expect("lb", 2'd0, 1'b0, 10'h040, 32'hFFFF_FFFF);
    ld_expect("lbu", 2'd0, 1'b1, 10'h040, 32'h0000_00FF);
    ld_expect("lh", 2'd1, 1'b0, 10'h040, 32'hFFFF_80FF);
    ld_expect("lhu", 2'd1, 1'b1, 10'h040, 32'h0000_80FF);

    err_expect("sh_mis", 1'b1, 2'd1, 10'h041);
    err_expect("lw_mis", 1'b0, 2'd2, 10'h042);
    err_expect("size11", 1'b0, 2'd3, 10'h040);
    ld_expect("unchanged", 2'd2, 1'b0, 10'h040, 32'h0000_80FF);

    step(1'b1, 1'b1, 2'd2, 1'b0, 10'h000, 32'h0000_0005);
    step(1'b1, 1'b0, 2'd2, 1'b0, 10'h000, 32'd0);
    idle(2);
    check("b2b_fwd_lat1", last_rd1, 32'h0000_0005);
    check("b2b_fwd_lat2", last_rd2, 32'h0000_0005);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) != 0), 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
           10'($urandom_range(0, 63)), $urandom);
    end
    idle(3);

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'd2, 1'b0, 10'h020, 32'd0);
    apply_reset();
    wait_init("run_rst");
    ld_expect("reinit_w020", 2'd2, 1'b0, 10'h020, 32'h0000_0008);

    step(1'b1, 1'b1, 2'd2, 1'b0, 10'h000, 32'h0000_AAAA);
    step(1'b1, 1'b1, 2'd2, 1'b0, 10'h3FC, 32'h0000_BBBB);
    idle(2);
    apply_reset();
    repeat (100) @(negedge clk);
    check("mid_init_ready", 32'(rdy1), 32'd0);
    apply_reset();
    wait_init("init_rst");
    ld_expect("sweep_first", 2'd2, 1'b0, 10'h000, 32'h0000_0000);
    ld_expect("sweep_last", 2'd2, 1'b0, 10'h3FC, 32'h0000_00FF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
